// File: rtl/axil_master_cmd.sv
// Command-port to AXI-Lite master bridge: one single-beat read or write in flight at a time.
// Optional `AXIL_MASTER_ADDR_CHECK_EN` rejects out-of-window or misaligned commands with DECERR.
module axil_master_cmd #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE      = 32'h0000_1000
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,

    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);
    localparam int STRB_W = AXI_DATA_WIDTH/8;
    localparam int LSB_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

    state_t state, state_n;
    logic aw_done, aw_done_n, w_done, w_done_n;
    logic cmd_ready_n, rsp_valid_n;
    logic awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_n;
    logic [1:0]                rsp_resp_n;
    logic                      load_cmd, addr_ok;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;

`ifdef AXIL_MASTER_ADDR_CHECK_EN
    logic [AXI_ADDR_WIDTH-1:0] addr_off;
    // Offset compare avoids overflow when ADDR_BASE+ADDR_SIZE wraps the address space
    assign addr_off = cmd_addr - ADDR_BASE;
    assign addr_ok  = (cmd_addr >= ADDR_BASE) && (addr_off < ADDR_SIZE) &&
                      (cmd_addr[LSB_W-1:0] == '0);
`else
    logic unused_cfg;
    assign unused_cfg = ^{ADDR_BASE, ADDR_SIZE, LSB_W[0]};
    assign addr_ok    = 1'b1;
`endif

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;

    always_comb begin
        state_n     = state;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        cmd_ready_n = cmd_ready;
        rsp_valid_n = rsp_valid;
        awvalid_n   = m_axil_awvalid;
        wvalid_n    = m_axil_wvalid;
        bready_n    = m_axil_bready;
        arvalid_n   = m_axil_arvalid;
        rready_n    = m_axil_rready;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        load_cmd    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    load_cmd    = 1'b1;
                    cmd_ready_n = 1'b0;
                    if (!addr_ok) begin
                        state_n     = RSP;
                        rsp_valid_n = 1'b1;
                        rsp_resp_n  = 2'b11;
                        rsp_rdata_n = '0;
                    end else if (cmd_we) begin
                        state_n   = WR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                    end else begin
                        state_n   = RD_A;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR: begin
                if (m_axil_awvalid && m_axil_awready) begin
                    aw_done_n = 1'b1;
                    awvalid_n = 1'b0;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    w_done_n = 1'b1;
                    wvalid_n = 1'b0;
                end
                if (aw_done_n && w_done_n) begin
                    state_n  = WR_B;
                    bready_n = 1'b1;
                end
            end
            WR_B: begin
                if (m_axil_bvalid) begin
                    state_n     = RSP;
                    bready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_resp_n  = m_axil_bresp;
                    rsp_rdata_n = '0;
                end
            end
            RD_A: begin
                if (m_axil_arready) begin
                    state_n   = RD_D;
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end
            end
            RD_D: begin
                if (m_axil_rvalid) begin
                    state_n     = RSP;
                    rready_n    = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_resp_n  = m_axil_rresp;
                    rsp_rdata_n = m_axil_rdata;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            state          <= state_n;
            aw_done        <= aw_done_n;
            w_done         <= w_done_n;
            cmd_ready      <= cmd_ready_n;
            rsp_valid      <= rsp_valid_n;
            m_axil_awvalid <= awvalid_n;
            m_axil_wvalid  <= wvalid_n;
            m_axil_bready  <= bready_n;
            m_axil_arvalid <= arvalid_n;
            m_axil_rready  <= rready_n;
            rsp_rdata      <= rsp_rdata_n;
            rsp_resp       <= rsp_resp_n;
            if (load_cmd) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
        end
    end
endmodule

// File: tb/tb_axil_master_cmd.sv
// Directed bench for axil_master_cmd with a small AXI-Lite GPIO slave model.
module tb_axil_master_cmd;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_master_cmd dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 aclk = ~aclk;

    // GPIO slave model: B follows the cycle after both AW and W are taken, R follows AR by one cycle
    logic        aw_got, w_got, b_stall;
    logic [1:0]  slv_resp;
    logic [31:0] gpio_out;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0; gpio_out <= '0;
        end else begin
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready) begin
                w_got <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) gpio_out[b*8 +: 8] <= wdata[b*8 +: 8];
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) &&
                !bvalid && !b_stall) begin
                bvalid <= 1'b1; bresp <= slv_resp; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rdata <= gpio_out; rresp <= slv_resp;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    int unsigned b_hs = 0, rsp_hs = 0, ar_vld_cyc = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0;
    always @(posedge aclk) begin
        if (bvalid && bready) b_hs <= b_hs + 1;
        if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
        if (arvalid) ar_vld_cyc <= ar_vld_cyc + 1;
        if (awvalid && awready) last_awaddr <= awaddr;
        if (arvalid && arready) last_araddr <= araddr;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with cmd_* already driven; returns after the accepting edge
    task automatic accept(input string nm, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end
        cmd_valid = 1'b0;
        chk({nm, " accept"}, 64'(ok), 64'd1);
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] exp_rd,
                          input logic [1:0] exp_resp, input int exp_lat, input string nm);
        bit ok;
        int lat;
        cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        accept(nm, ok);
        if (!ok) return;
        lat = 0; ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge aclk);
            lat++;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk({nm, " rsp_valid seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({nm, " resp"}, 64'(rsp_resp), 64'(exp_resp));
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
        @(negedge aclk);
        chk({nm, " cmd_ready after rsp"}, {63'd0, cmd_ready}, 64'd1);
        chk({nm, " rsp_valid dropped"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  slv;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
        logic [31:0] exp_gpio;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [12:0] out_bits();
        return {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                |rsp_resp, |rsp_rdata, |awaddr, |araddr, |wdata, |wstrb};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int aw_hi, w_hi, hold_crdy, hold_vld;
        int unsigned b0, r0;
        bit stable;
        logic [31:0] rd0;
        logic [1:0]  rs0;

        vecs[0] = '{1'b1, 32'h0, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0,         2'b00, 3, 32'hA5A5_5A5A};
        vecs[1] = '{1'b0, 32'h0, 32'h0,         4'h0, 2'b00, 32'hA5A5_5A5A, 2'b00, 3, 32'hA5A5_5A5A};
        vecs[2] = '{1'b1, 32'h0, 32'h1234_5678, 4'h3, 2'b00, 32'h0,         2'b00, 3, 32'hA5A5_5678};
        vecs[3] = '{1'b0, 32'h4, 32'h0,         4'h0, 2'b00, 32'hA5A5_5678, 2'b00, 3, 32'hA5A5_5678};
        vecs[4] = '{1'b1, 32'h8, 32'hFFFF_FFFF, 4'h8, 2'b10, 32'h0,         2'b10, 3, 32'hFFA5_5678};
        vecs[5] = '{1'b0, 32'h0, 32'h0,         4'h0, 2'b10, 32'hFFA5_5678, 2'b10, 3, 32'hFFA5_5678};

        aresetn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0; awready = 1'b1; wready = 1'b1; arready = 1'b1;
        b_stall = 1'b0; slv_resp = 2'b00;

        repeat (3) @(negedge aclk);
        chk("reset outputs", 64'(out_bits()), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("cmd_ready after release", {63'd0, cmd_ready}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            slv_resp = vecs[i].slv;
            do_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].exp_lat, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d gpio", i), 64'(gpio_out), 64'(vecs[i].exp_gpio));
            chk($sformatf("vec%0d addr", i), 64'(vecs[i].we ? last_awaddr : last_araddr),
                64'(vecs[i].addr));
        end
        slv_resp = 2'b00;

        // W accepted four cycles after AW
        b0 = b_hs; r0 = rsp_hs;
        wready = 1'b0;
        cmd_we = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
        accept("slow w", ok);
        aw_hi = 0; w_hi = 0; ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge aclk);
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            wready = (k == 5);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        wready = 1'b1;
        chk("slow w rsp_valid seen", 64'(ok), 64'd1);
        chk("slow w awvalid cycles", 64'(aw_hi), 64'd1);
        chk("slow w wvalid cycles", 64'(w_hi), 64'd5);
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        chk("slow w b handshakes", 64'(b_hs - b0), 64'd1);
        chk("slow w responses", 64'(rsp_hs - r0), 64'd1);
        chk("slow w gpio", 64'(gpio_out), 64'h0BAD_F00D);

        // Response back-pressure with a new command waiting
        cmd_we = 1'b0; cmd_addr = 32'h0;
        accept("hold", ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge aclk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("hold rsp_valid seen", 64'(ok), 64'd1);
        rd0 = rsp_rdata; rs0 = rsp_resp;
        chk("hold rdata", 64'(rd0), 64'h0BAD_F00D);
        cmd_valid = 1'b1; cmd_we = 1'b1;
        stable = 1'b1; hold_crdy = 0; hold_vld = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge aclk);
            if (!rsp_valid || rsp_rdata !== rd0 || rsp_resp !== rs0) stable = 1'b0;
            if (cmd_ready) hold_crdy++;
            if (awvalid || wvalid || arvalid) hold_vld++;
        end
        cmd_valid = 1'b0;
        chk("hold rsp stable", 64'(stable), 64'd1);
        chk("hold cmd_ready cycles", 64'(hold_crdy), 64'd0);
        chk("hold axi valid cycles", 64'(hold_vld), 64'd0);
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1 rsp_ready = 1'b0;
        @(negedge aclk);
        chk("back-to-back cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Reset while waiting on B
        r0 = rsp_hs;
        b_stall = 1'b1;
        cmd_we = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        accept("rst wr_b", ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge aclk);
            if (bready) begin ok = 1'b1; break; end
        end
        chk("rst reached wr_b", 64'(ok), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("rst async outputs", 64'(out_bits()), 64'd0);
        @(negedge aclk);
        chk("rst held outputs", 64'(out_bits()), 64'd0);
        b_stall = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst cmd_ready after release", {63'd0, cmd_ready}, 64'd1);
        chk("rst no response", 64'(rsp_hs - r0), 64'd0);
        do_cmd(1'b1, 32'h0, 32'h0F0F_0F0F, 4'hF, 32'h0, 2'b00, 3, "post-rst wr");
        chk("post-rst gpio", 64'(gpio_out), 64'h0F0F_0F0F);

`ifdef AXIL_MASTER_ADDR_CHECK_EN
        b0 = ar_vld_cyc;
        do_cmd(1'b0, 32'h2000, 32'h0, 4'h0, 32'h0, 2'b11, 1, "decerr range");
        do_cmd(1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 2'b11, 1, "decerr align");
        chk("decerr no arvalid", 64'(ar_vld_cyc - b0), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_master_cmd.md
# axil_master_cmd

Command-to-AXI-Lite master bridge that sits directly upstream of the AXI-Lite GPIO slave and drives its `s_axil` port. It accepts one single-beat read or write command at a time on a valid/ready command port, runs the matching AXI-Lite transaction, and returns the read data and response on a valid/ready response port. It is used by test sequencers and small control FSMs that program `gpio_out` without their own AXI logic.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: data width; must be 32 or 64.
- `AXI_ADDR_WIDTH`, 32: address width.
- `ADDR_BASE`, 32'h0000_0000: first legal address; used only with `AXIL_MASTER_ADDR_CHECK_EN`.
- `ADDR_SIZE`, 32'h0000_1000: legal window size in bytes; used only with `AXIL_MASTER_ADDR_CHECK_EN`.

Ports:
- `aclk`  in  1  clock; the only clock.
- `aresetn`  in  1  reset; asynchronous assert, active-low.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AXI_ADDR_WIDTH  byte address.
- `cmd_wdata`  in  AXI_DATA_WIDTH  write data.
- `cmd_wstrb`  in  AXI_DATA_WIDTH/8  write strobes.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  AXI_DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP or RRESP of the transaction.
- `m_axil_*`  AXI-Lite master channels: AW (`awaddr`, `awvalid`, `awready`), W (`wdata`, `wstrb`, `wvalid`, `wready`), B (`bresp`, `bvalid`, `bready`), AR (`araddr`, `arvalid`, `arready`), R (`rdata`, `rresp`, `rvalid`, `rready`). Directions and widths mirror the slave port.

## Operation
- FSM states:
  - `IDLE`: `cmd_ready`=1. On `cmd_valid`, latch all `cmd_*` fields, then go to `WR` if `cmd_we`=1, otherwise `RD_A`.
  - `WR`: `awvalid` and `wvalid` assert together. Each drops individually after its own handshake, tracked by `aw_done` and `w_done` flags. When both are done, go to `WR_B`.
  - `WR_B`: `bready`=1. On `bvalid`, latch `bresp` and go to `RSP`.
  - `RD_A`: `arvalid`=1 until `arready`, then go to `RD_D`.
  - `RD_D`: `rready`=1. On `rvalid`, latch `rdata` and `rresp`, then go to `RSP`.
  - `RSP`: `rsp_valid`=1 and its data held stable. On `rsp_ready`, go to `IDLE`.
- Only one transaction is outstanding at a time. No new command is accepted until the response has been consumed.
- All AXI outputs are registered and are driven from latched command fields.
- Each valid stays high until its handshake completes, independent of the ready level (AXI rule).
- AW and W handshakes completing in the same cycle set both done flags, and the FSM enters `WR_B` on the next cycle.
- `rsp_resp` passes the slave's code through unmodified, including SLVERR (2'b10).

## Timing
- Reset values: all valid/ready outputs are 0; `cmd_ready`=0 during reset and 1 in the first cycle after release; all address/data/resp outputs are 0.
- Zero-wait write: command accepted in cycle N; AW/W handshake in N+1; B handshake in N+2 at earliest; `rsp_valid` in N+3.
- Zero-wait read: accepted in cycle N; AR handshake in N+1; R handshake in N+2; `rsp_valid` in N+3.
- Back-to-back: the next command can be accepted in the cycle after the `rsp_valid`/`rsp_ready` handshake.
- `aresetn` low mid-transaction: the FSM returns to `IDLE` immediately and all valids drop asynchronously. The in-flight transaction is abandoned and no response is produced.

## Configuration
- `AXIL_MASTER_ADDR_CHECK_EN` defined: a command whose address is outside [`ADDR_BASE`, `ADDR_BASE`+`ADDR_SIZE`) or is not aligned to `AXI_DATA_WIDTH`/8 bytes issues no AXI traffic. The FSM goes `IDLE` → `RSP` with `rsp_resp`=2'b11 (DECERR) and `rsp_rdata`=0; `rsp_valid` asserts in the cycle after acceptance.
- Not defined: every command is issued on AXI unchecked. `ADDR_BASE` and `ADDR_SIZE` are ignored.

## Test plan
- Write addr 0x0, data 0xA5A5_5A5A, strb 0xF, zero-wait slave -> `rsp_valid` 3 cycles after acceptance, `rsp_resp`=0, `gpio_out`=0xA5A5_5A5A.
- Read addr 0x0 after that write -> `rsp_rdata`=0xA5A5_5A5A, `rsp_resp`=0, latency 3 cycles.
- Write with `wready` delayed 4 cycles past `awready` -> `awvalid` drops after 1 cycle, `wvalid` held 5 cycles, exactly one B handshake and one response.
- Hold `rsp_ready`=0 for 6 cycles -> `rsp_*` stable, `cmd_ready`=0 throughout, no AXI valid asserted.
- Assert `aresetn` low while in `WR_B` -> all outputs at reset values; write to 0x0 after release completes normally.
- With `AXIL_MASTER_ADDR_CHECK_EN`, `ADDR_SIZE`=0x1000: read 0x2000 or 0x2 -> `rsp_resp`=2'b11 one cycle after acceptance, no `arvalid`.
